// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: IM port, redirect/halt control, decode handshake and status.
// FETCH_PERF_EN adds the two performance counter outputs.
interface fetch_ctrl_if;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        dec_ready;
    logic        fault;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    modport master (
        output im_addr,
        input  im_instr,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        output f_valid,
        output f_instr,
        output f_pc,
        input  dec_ready,
        output fault,
        output fetch_state
`ifdef FETCH_PERF_EN
        , output perf_fetch_cnt
        , output perf_stall_cnt
`endif
    );

    modport slave (
        input  im_addr,
        output im_instr,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        input  f_valid,
        input  f_instr,
        input  f_pc,
        output dec_ready,
        input  fault,
        input  fetch_state
`ifdef FETCH_PERF_EN
        , input perf_fetch_cnt
        , input perf_stall_cnt
`endif
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, IM addressing, circular fetch buffer,
// redirect/halt/fault handling. Define FETCH_PERF_EN to add push/stall counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 4096,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [32:0]      PC_END  = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // 33-bit compare so that a wrapped pc can never look legal.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a} < {1'b0, RESET_PC}) || ({1'b0, a} >= PC_END);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] tail_of(input logic [PTR_W-1:0] h,
                                                 input logic [CNT_W-1:0] c);
        int s;
        s = int'(h) + int'(c);
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [PTR_W-1:0] r_head, w_head_nxt;
    logic             r_fault, w_fault_nxt;
    logic             w_push, w_pop, w_flush, w_valid, w_can_accept;
    logic [PTR_W-1:0] w_tail;

    logic [31:0]      r_buf_pc    [DEPTH];
    logic [31:0]      r_buf_instr [DEPTH];

    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && bus.dec_ready;
    assign w_can_accept = (r_count < DEPTH_C) || w_pop;
    assign w_tail       = tail_of(r_head, r_count);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_FETCH;
            ST_FETCH, ST_FULL: begin
                if (bus.halt_req) begin
                    w_flush     = bus.redirect_valid;
                    w_state_nxt = ST_HALT;
                end else if (bus.redirect_valid) begin
                    if (addr_bad(bus.redirect_target)) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_flush     = 1'b1;
                        w_pc_nxt    = bus.redirect_target;
                        w_state_nxt = ST_FETCH;
                    end
                end else if (r_state == ST_FULL) begin
                    // FULL never pushes; the bubble after a pop is intentional.
                    if (w_pop) w_state_nxt = ST_FETCH;
                end else if (w_can_accept && addr_bad(r_pc)) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else begin
                    w_push = w_can_accept;
                    if (w_push) w_pc_nxt = r_pc + 32'd4;
                    if (!w_pop && (r_count + CNT_W'(w_push) == DEPTH_C)) w_state_nxt = ST_FULL;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        w_head_nxt = w_pop ? ptr_inc(r_head) : r_head;
        if (w_flush) w_count_nxt = '0;
        else         w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_head  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Buffer payload is unreset; outputs are masked by the count instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[w_tail]    <= r_pc;
            r_buf_instr[w_tail] <= bus.im_instr;
        end
    end

    assign bus.im_addr     = r_pc;
    assign bus.f_valid     = w_valid;
    assign bus.f_instr     = w_valid ? r_buf_instr[r_head] : 32'd0;
    assign bus.f_pc        = w_valid ? r_buf_pc[r_head] : 32'd0;
    assign bus.fault       = r_fault;
    assign bus.fetch_state = r_state;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch, r_perf_stall;
    logic        w_active;

    assign w_active = (r_state == ST_FETCH) || (r_state == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push && (r_perf_fetch != 32'hFFFF_FFFF))
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_active && !w_push && !bus.redirect_valid && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign bus.perf_fetch_cnt = r_perf_fetch;
    assign bus.perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a combinational IM model where word k holds k.
module tb_fetch_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.im_instr = (bus.im_addr - 32'h0000_3000) >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic dr);
        rst_n               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        bus.halt_req        = 1'b0;
        bus.dec_ready       = dr;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        bus.halt_req        = 1'b0;
        bus.dec_ready       = 1'b0;
        tick();
        tick();
        checks++; if (bus.fetch_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.fetch_state); end
        checks++; if (bus.im_addr !== 32'h3000) begin failures++; $display("FAIL rst_im_addr got=%h exp=00003000", bus.im_addr); end
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL rst_f_valid got=%b exp=0", bus.f_valid); end
        checks++; if (bus.f_instr !== 32'd0) begin failures++; $display("FAIL rst_f_instr got=%h exp=0", bus.f_instr); end
        checks++; if (bus.f_pc !== 32'd0) begin failures++; $display("FAIL rst_f_pc got=%h exp=0", bus.f_pc); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", bus.fault); end
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (bus.fetch_state !== 2'd2) begin failures++; $display("FAIL midop_state got=%0d exp=2", bus.fetch_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL midrst_f_valid got=%b exp=0", bus.f_valid); end
        checks++; if (bus.im_addr !== 32'h3000) begin failures++; $display("FAIL midrst_im_addr got=%h exp=00003000", bus.im_addr); end
        checks++; if (bus.fetch_state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", bus.fetch_state); end
        tick();
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        checks++; if (bus.fetch_state !== 2'd0) begin failures++; $display("FAIL boot_state got=%0d exp=0", bus.fetch_state); end
        tick();
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL boot_nopush got=%b exp=0", bus.f_valid); end
        checks++; if (bus.fetch_state !== 2'd1) begin failures++; $display("FAIL fetch_state got=%0d exp=1", bus.fetch_state); end
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.f_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus.f_valid); end
            checks++; if (bus.f_pc !== 32'h3000 + 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.f_pc, 32'h3000 + 32'(4 * i)); end
            checks++; if (bus.f_instr !== 32'(i)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, bus.f_instr, i); end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset(1'b0);
        tick();
        tick();
        tick();
        checks++; if (bus.fetch_state !== 2'd2) begin failures++; $display("FAIL full_state got=%0d exp=2", bus.fetch_state); end
        tick();
        tick();
        checks++; if (bus.im_addr !== 32'h3008) begin failures++; $display("FAIL full_hold_addr got=%h exp=00003008", bus.im_addr); end
        bus.dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.f_pc !== 32'h3000 + 32'(4 * k) || bus.f_valid !== 1'b1) begin failures++; $display("FAIL full_order[%0d] got=%h exp=%h", k, bus.f_pc, 32'h3000 + 32'(4 * k)); end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        tick();
        tick();
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h3040;
        tick();
        bus.redirect_valid  = 1'b0;
        checks++; if (bus.im_addr !== 32'h3040) begin failures++; $display("FAIL redir_addr got=%h exp=00003040", bus.im_addr); end
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", bus.f_valid); end
        tick();
        checks++; if (bus.f_pc !== 32'h3040) begin failures++; $display("FAIL redir_f_pc got=%h exp=00003040", bus.f_pc); end
        checks++; if (bus.f_instr !== 32'h10) begin failures++; $display("FAIL redir_f_instr got=%h exp=00000010", bus.f_instr); end
    endtask

    task automatic test_fault();
        do_reset(1'b0);
        tick();
        tick();
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h3042;
        tick();
        checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL misalign_fault got=%b exp=1", bus.fault); end
        checks++; if (bus.fetch_state !== 2'd3) begin failures++; $display("FAIL misalign_state got=%0d exp=3", bus.fetch_state); end
        checks++; if (bus.im_addr !== 32'h3008) begin failures++; $display("FAIL misalign_pc got=%h exp=00003008", bus.im_addr); end
        bus.redirect_target = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.im_addr !== 32'h3008) begin failures++; $display("FAIL halt_ignore_redir got=%h exp=00003008", bus.im_addr); end
        bus.dec_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus.f_pc !== 32'h3000 + 32'(4 * k) || bus.f_valid !== 1'b1) begin failures++; $display("FAIL drain[%0d] got=%h exp=%h", k, bus.f_pc, 32'h3000 + 32'(4 * k)); end
            tick();
        end
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.f_valid); end
        do_reset(1'b1);
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0;
        tick();
        bus.redirect_valid  = 1'b0;
        checks++; if (bus.fault !== 1'b1 || bus.fetch_state !== 2'd3) begin failures++; $display("FAIL range_fault got=%b/%0d exp=1/3", bus.fault, bus.fetch_state); end
        checks++; if (bus.im_addr !== 32'h3000) begin failures++; $display("FAIL range_pc got=%h exp=00003000", bus.im_addr); end
    endtask

    task automatic test_halt_redirect();
        do_reset(1'b0);
        tick();
        tick();
        tick();
        bus.halt_req        = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h3040;
        tick();
        bus.halt_req       = 1'b0;
        bus.redirect_valid = 1'b0;
        checks++; if (bus.fetch_state !== 2'd3) begin failures++; $display("FAIL hr_state got=%0d exp=3", bus.fetch_state); end
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL hr_flush got=%b exp=0", bus.f_valid); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL hr_fault got=%b exp=0", bus.fault); end
        tick();
        tick();
        tick();
        checks++; if (bus.im_addr !== 32'h3008) begin failures++; $display("FAIL hr_addr got=%h exp=00003008", bus.im_addr); end
    endtask

    task automatic test_end_of_range();
        logic [31:0] last_pc;
        logic [31:0] last_instr;
        bit          done;
        last_pc    = 32'd0;
        last_instr = 32'd0;
        done       = 1'b0;
        do_reset(1'b1);
        for (int c = 0; c < 5000 && !done; c++) begin
            tick();
            if (bus.f_valid) begin
                last_pc    = bus.f_pc;
                last_instr = bus.f_instr;
            end
            if (bus.fault) done = 1'b1;
        end
        checks++; if (!done) begin failures++; $display("FAIL end_timeout got=nofault exp=fault"); end
        checks++; if (bus.fetch_state !== 2'd3) begin failures++; $display("FAIL end_state got=%0d exp=3", bus.fetch_state); end
        checks++; if (last_pc !== 32'h6FFC) begin failures++; $display("FAIL end_last_pc got=%h exp=00006ffc", last_pc); end
        checks++; if (last_instr !== 32'hFFF) begin failures++; $display("FAIL end_last_instr got=%h exp=00000fff", last_instr); end
        checks++; if (bus.im_addr !== 32'h7000) begin failures++; $display("FAIL end_pc got=%h exp=00007000", bus.im_addr); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_fault();
        test_halt_redirect();
        test_end_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
